// File: rtl/axis_packet_splitter_mc_pkg.sv
// rtl/axis_packet_splitter_mc_pkg.sv - shared state encoding and sideband width helpers
package axis_packet_splitter_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } split_state_e;

    function automatic int keep_width_f(input bit enable, input int data_width);
        return enable ? (data_width + 7) / 8 : 1;
    endfunction

    function automatic int side_width_f(input bit enable, input int width);
        return enable ? width : 1;
    endfunction

endpackage

// File: rtl/axis_split_channel_ctrl.sv
// rtl/axis_split_channel_ctrl.sv - per-lane beat/packet counters, tlast generation and done flag
module axis_split_channel_ctrl #(
    parameter int PCKT_WIDTH          = 32,
    parameter int CNT_WIDTH           = 16,
    parameter bit RAISE_NON_DIVISIBLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  handshake,
    input  logic                  in_tlast,
    input  logic [PCKT_WIDTH-1:0] size,
    input  logic [CNT_WIDTH-1:0]  count,
    output logic                  out_tlast,
    output logic                  done,
    output logic                  done_set,
    output logic                  nondiv_error
);

    logic [PCKT_WIDTH-1:0] beat_cnt;
    logic [CNT_WIDTH-1:0]  pkt_cnt;
    logic                  at_last;
    logic                  last_pkt;

    // Only latched size/count are compared, so mid-run input changes are harmless.
    assign at_last      = (beat_cnt == size - PCKT_WIDTH'(1));
    assign last_pkt     = (pkt_cnt == count - CNT_WIDTH'(1));
    assign out_tlast    = at_last;
    assign done_set     = handshake && at_last && last_pkt;
    assign nondiv_error = RAISE_NON_DIVISIBLE && handshake && in_tlast && !at_last;

    // Advance beat counter per accepted beat; wrap at packet end and bump the packet counter.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            beat_cnt <= '0;
            pkt_cnt  <= '0;
            done     <= 1'b0;
        end else if (handshake) begin
            if (at_last) begin
                beat_cnt <= '0;
                pkt_cnt  <= pkt_cnt + CNT_WIDTH'(1);
                if (last_pkt) begin
                    done <= 1'b1;
                end
            end else begin
                beat_cnt <= beat_cnt + PCKT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/axis_packet_splitter_mc.sv
// rtl/axis_packet_splitter_mc.sv - multi-channel stream splitter with packet count, lock and error handling
module axis_packet_splitter_mc
    import axis_packet_splitter_mc_pkg::*;
#(
    parameter int CHANNELS            = 1,
    parameter int DATA_WIDTH          = 16,
    parameter bit KEEP_ENABLE         = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH          = keep_width_f(KEEP_ENABLE, DATA_WIDTH),
    parameter bit ID_ENABLE           = 1'b0,
    parameter int ID_WIDTH            = side_width_f(ID_ENABLE, 8),
    parameter bit DEST_ENABLE         = 1'b0,
    parameter int DEST_WIDTH          = side_width_f(DEST_ENABLE, 8),
    parameter bit USER_ENABLE         = 1'b0,
    parameter int USER_WIDTH          = side_width_f(USER_ENABLE, 8),
    parameter int PCKT_WIDTH          = 32,
    parameter int CNT_WIDTH           = 16,
    parameter bit ALLOW_LOCKS         = 1'b1,
    parameter bit RAISE_NON_DIVISIBLE = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           operation_start,
    input  logic [PCKT_WIDTH-1:0]          packet_size,
    input  logic [CNT_WIDTH-1:0]           packet_count,
    input  logic                           lock,
    input  logic                           external_error,
    output logic                           operation_busy,
    output logic                           operation_complete,
    output logic                           operation_error,
    output logic [CHANNELS-1:0]            channel_done,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CHANNELS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [CHANNELS-1:0]            s_axis_tvalid,
    output logic [CHANNELS-1:0]            s_axis_tready,
    input  logic [CHANNELS-1:0]            s_axis_tlast,
    input  logic [CHANNELS*ID_WIDTH-1:0]   s_axis_tid,
    input  logic [CHANNELS*DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [CHANNELS*USER_WIDTH-1:0] s_axis_tuser,
    output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [CHANNELS*KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [CHANNELS-1:0]            m_axis_tvalid,
    input  logic [CHANNELS-1:0]            m_axis_tready,
    output logic [CHANNELS-1:0]            m_axis_tlast,
    output logic [CHANNELS*ID_WIDTH-1:0]   m_axis_tid,
    output logic [CHANNELS*DEST_WIDTH-1:0] m_axis_tdest,
    output logic [CHANNELS*USER_WIDTH-1:0] m_axis_tuser
);

    split_state_e          state_q, state_d;
    logic [PCKT_WIDTH-1:0] size_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  complete_q;
    logic                  run;
    logic                  locked;
    logic                  start_ok;
    logic                  clear;
    logic                  go_done;
    logic [CHANNELS-1:0]   active;
    logic [CHANNELS-1:0]   handshake;
    logic [CHANNELS-1:0]   ch_tlast;
    logic [CHANNELS-1:0]   done_q;
    logic [CHANNELS-1:0]   done_set;
    logic [CHANNELS-1:0]   nondiv;

    assign run      = (state_q == ST_RUN);
    assign locked   = ALLOW_LOCKS && lock;
    assign start_ok = operation_start && (packet_size != '0) && (packet_count != '0);

    // A finished lane stops handshaking so it cannot run past its packet budget.
    assign active        = {CHANNELS{run && !locked}} & ~done_q;
    assign handshake     = s_axis_tvalid & m_axis_tready & active;
    assign m_axis_tvalid = s_axis_tvalid & active;
    assign s_axis_tready = m_axis_tready & active;
    assign m_axis_tlast  = ch_tlast & {CHANNELS{run}};

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tkeep = KEEP_ENABLE ? s_axis_tkeep : '1;
    assign m_axis_tid   = ID_ENABLE   ? s_axis_tid   : '0;
    assign m_axis_tdest = DEST_ENABLE ? s_axis_tdest : '0;
    assign m_axis_tuser = USER_ENABLE ? s_axis_tuser : '0;

    assign operation_busy     = run;
    assign operation_complete = complete_q;
    assign operation_error    = (state_q == ST_ERROR);
    assign channel_done       = done_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        axis_split_channel_ctrl #(
            .PCKT_WIDTH          (PCKT_WIDTH),
            .CNT_WIDTH           (CNT_WIDTH),
            .RAISE_NON_DIVISIBLE (RAISE_NON_DIVISIBLE)
        ) u_ctrl (
            .clk          (clk),
            .rst          (rst),
            .clear        (clear),
            .handshake    (handshake[i]),
            .in_tlast     (s_axis_tlast[i]),
            .size         (size_q),
            .count        (count_q),
            .out_tlast    (ch_tlast[i]),
            .done         (done_q[i]),
            .done_set     (done_set[i]),
            .nondiv_error (nondiv[i])
        );
    end

    // Next-state: errors take priority over completion so a failing run never reports done.
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        go_done = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (external_error) begin
                    state_d = ST_ERROR;
                end else if (operation_start) begin
                    if (start_ok) begin
                        state_d = ST_RUN;
                        clear   = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_RUN: begin
                if (external_error || (|nondiv)) begin
                    state_d = ST_ERROR;
                end else if (&(done_q | done_set)) begin
                    state_d = ST_IDLE;
                    go_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, registered completion pulse and operation parameter latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            size_q     <= '0;
            count_q    <= '0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            complete_q <= go_done;
            if (clear) begin
                size_q  <= packet_size;
                count_q <= packet_count;
            end
        end
    end

endmodule

// File: tb/tb_axis_packet_splitter_mc.sv
// tb/tb_axis_packet_splitter_mc.sv - directed self-checking bench for axis_packet_splitter_mc
module tb_axis_packet_splitter_mc;

    localparam int CH = 2;
    localparam int DW = 16;
    localparam int KW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          operation_start;
    logic [31:0]   packet_size;
    logic [15:0]   packet_count;
    logic          lock;
    logic          external_error;
    logic          operation_busy;
    logic          operation_complete;
    logic          operation_error;
    logic [CH-1:0] channel_done;
    logic [CH*DW-1:0] s_axis_tdata;
    logic [CH*KW-1:0] s_axis_tkeep;
    logic [CH-1:0] s_axis_tvalid;
    logic [CH-1:0] s_axis_tready;
    logic [CH-1:0] s_axis_tlast;
    logic [CH-1:0] s_axis_tid;
    logic [CH-1:0] s_axis_tdest;
    logic [CH-1:0] s_axis_tuser;
    logic [CH*DW-1:0] m_axis_tdata;
    logic [CH*KW-1:0] m_axis_tkeep;
    logic [CH-1:0] m_axis_tvalid;
    logic [CH-1:0] m_axis_tready;
    logic [CH-1:0] m_axis_tlast;
    logic [CH-1:0] m_axis_tid;
    logic [CH-1:0] m_axis_tdest;
    logic [CH-1:0] m_axis_tuser;

    int vectors = 0;
    int miscompares = 0;

    axis_packet_splitter_mc #(.CHANNELS(CH), .DATA_WIDTH(DW)) dut (
        .clk                (clk),
        .rst                (rst),
        .operation_start    (operation_start),
        .packet_size        (packet_size),
        .packet_count       (packet_count),
        .lock               (lock),
        .external_error     (external_error),
        .operation_busy     (operation_busy),
        .operation_complete (operation_complete),
        .operation_error    (operation_error),
        .channel_done       (channel_done),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tkeep       (s_axis_tkeep),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tid         (s_axis_tid),
        .s_axis_tdest       (s_axis_tdest),
        .s_axis_tuser       (s_axis_tuser),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tkeep       (m_axis_tkeep),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_tid         (m_axis_tid),
        .m_axis_tdest       (m_axis_tdest),
        .m_axis_tuser       (m_axis_tuser)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] sz, input logic [15:0] ct);
        operation_start = 1'b1;
        packet_size     = sz;
        packet_count    = ct;
        step();
        operation_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_axis_tvalid = 2'b11;
        m_axis_tready = 2'b11;
        step();
        step();
        vectors++; if (operation_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", operation_busy); end
        vectors++; if (operation_complete !== 1'b0) begin miscompares++; $display("FAIL reset_complete got %b want 0", operation_complete); end
        vectors++; if (operation_error !== 1'b0) begin miscompares++; $display("FAIL reset_error got %b want 0", operation_error); end
        vectors++; if (channel_done !== 2'b00) begin miscompares++; $display("FAIL reset_done got %b want 00", channel_done); end
        vectors++; if (s_axis_tready !== 2'b00) begin miscompares++; $display("FAIL reset_tready got %b want 00", s_axis_tready); end
        vectors++; if (m_axis_tvalid !== 2'b00) begin miscompares++; $display("FAIL reset_tvalid got %b want 00", m_axis_tvalid); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_split();
        logic [1:0] exp_last;
        logic [31:0] exp_data;
        s_axis_tvalid = 2'b11;
        m_axis_tready = 2'b11;
        s_axis_tlast  = 2'b00;
        do_start(32'd4, 16'd3);
        vectors++; if (operation_busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %b want 1", operation_busy); end
        for (int b = 1; b <= 12; b++) begin
            exp_data = {16'(256 + b), 16'(b)};
            s_axis_tdata = exp_data;
            @(negedge clk);
            exp_last = (b % 4 == 0) ? 2'b11 : 2'b00;
            vectors++; if (m_axis_tlast !== exp_last) begin miscompares++; $display("FAIL basic_tlast beat %0d got %b want %b", b, m_axis_tlast, exp_last); end
            vectors++; if (m_axis_tdata !== exp_data) begin miscompares++; $display("FAIL basic_tdata beat %0d got %h want %h", b, m_axis_tdata, exp_data); end
            vectors++; if (m_axis_tvalid !== 2'b11) begin miscompares++; $display("FAIL basic_tvalid beat %0d got %b want 11", b, m_axis_tvalid); end
            step();
        end
        vectors++; if (m_axis_tkeep !== 4'b1111) begin miscompares++; $display("FAIL basic_tkeep got %b want 1111", m_axis_tkeep); end
        vectors++; if (operation_complete !== 1'b1) begin miscompares++; $display("FAIL basic_complete got %b want 1", operation_complete); end
        vectors++; if (operation_busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_end got %b want 0", operation_busy); end
        vectors++; if (channel_done !== 2'b11) begin miscompares++; $display("FAIL basic_done got %b want 11", channel_done); end
        step();
        vectors++; if (operation_complete !== 1'b0) begin miscompares++; $display("FAIL basic_complete_pulse got %b want 0", operation_complete); end
        vectors++; if (channel_done !== 2'b11) begin miscompares++; $display("FAIL basic_done_hold got %b want 11", channel_done); end
    endtask

    task automatic test_skewed();
        int n0 = 0;
        int n1 = 0;
        logic [1:0] rdy, exp_done, exp_last, hs;
        s_axis_tvalid = 2'b11;
        do_start(32'd4, 16'd3);
        for (int cyc = 0; cyc < 80 && n1 < 12; cyc++) begin
            rdy = {1'(cyc % 2), 1'b1};
            m_axis_tready = rdy;
            exp_done = {(n1 == 12), (n0 == 12)};
            exp_last = {(n1 % 4 == 3), (n0 % 4 == 3)};
            @(negedge clk);
            vectors++; if (s_axis_tready !== (rdy & ~exp_done)) begin miscompares++; $display("FAIL skew_tready cyc %0d got %b want %b", cyc, s_axis_tready, rdy & ~exp_done); end
            vectors++; if (m_axis_tlast !== exp_last) begin miscompares++; $display("FAIL skew_tlast cyc %0d got %b want %b", cyc, m_axis_tlast, exp_last); end
            vectors++; if (channel_done !== exp_done) begin miscompares++; $display("FAIL skew_done cyc %0d got %b want %b", cyc, channel_done, exp_done); end
            hs = rdy & ~exp_done;
            step();
            n0 += int'(hs[0]);
            n1 += int'(hs[1]);
            if (n1 < 12) begin
                vectors++; if (operation_complete !== 1'b0) begin miscompares++; $display("FAIL skew_early_complete cyc %0d got %b want 0", cyc, operation_complete); end
            end
        end
        vectors++;
        if (n1 != 12) begin
            miscompares++; $display("FAIL skew_timeout ch1 beats got %0d want 12", n1);
        end else begin
            vectors++; if (operation_complete !== 1'b1) begin miscompares++; $display("FAIL skew_complete got %b want 1", operation_complete); end
            vectors++; if (channel_done !== 2'b11) begin miscompares++; $display("FAIL skew_done_end got %b want 11", channel_done); end
        end
        m_axis_tready = 2'b11;
        step();
    endtask

    task automatic test_nondiv();
        s_axis_tvalid = 2'b11;
        m_axis_tready = 2'b11;
        s_axis_tlast  = 2'b00;
        do_start(32'd4, 16'd3);
        for (int b = 1; b <= 6; b++) begin
            s_axis_tlast = (b == 6) ? 2'b01 : 2'b00;
            @(negedge clk);
            if (b == 6) begin
                vectors++; if (m_axis_tvalid !== 2'b11) begin miscompares++; $display("FAIL nondiv_fwd got %b want 11", m_axis_tvalid); end
                vectors++; if (m_axis_tlast !== 2'b00) begin miscompares++; $display("FAIL nondiv_tlast got %b want 00", m_axis_tlast); end
            end
            step();
        end
        s_axis_tlast = 2'b00;
        vectors++; if (operation_error !== 1'b1) begin miscompares++; $display("FAIL nondiv_error got %b want 1", operation_error); end
        vectors++; if (s_axis_tready !== 2'b00) begin miscompares++; $display("FAIL nondiv_tready got %b want 00", s_axis_tready); end
        vectors++; if (m_axis_tvalid !== 2'b00) begin miscompares++; $display("FAIL nondiv_tvalid got %b want 00", m_axis_tvalid); end
        vectors++; if (operation_busy !== 1'b0) begin miscompares++; $display("FAIL nondiv_busy got %b want 0", operation_busy); end
        step();
        vectors++; if (operation_error !== 1'b1) begin miscompares++; $display("FAIL nondiv_sticky got %b want 1", operation_error); end
        do_start(32'd2, 16'd1);
        vectors++; if (operation_error !== 1'b0) begin miscompares++; $display("FAIL nondiv_clear got %b want 0", operation_error); end
        vectors++; if (operation_busy !== 1'b1) begin miscompares++; $display("FAIL nondiv_rerun got %b want 1", operation_busy); end
        for (int b = 1; b <= 2; b++) begin
            @(negedge clk);
            vectors++; if (m_axis_tlast !== ((b == 2) ? 2'b11 : 2'b00)) begin miscompares++; $display("FAIL nondiv_rerun_tlast beat %0d got %b", b, m_axis_tlast); end
            step();
        end
        vectors++; if (operation_complete !== 1'b1) begin miscompares++; $display("FAIL nondiv_rerun_complete got %b want 1", operation_complete); end
        step();
    endtask

    task automatic test_lock();
        s_axis_tvalid = 2'b11;
        m_axis_tready = 2'b11;
        do_start(32'd4, 16'd1);
        step();
        step();
        lock = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++; if (m_axis_tvalid !== 2'b00) begin miscompares++; $display("FAIL lock_tvalid cyc %0d got %b want 00", c, m_axis_tvalid); end
            vectors++; if (s_axis_tready !== 2'b00) begin miscompares++; $display("FAIL lock_tready cyc %0d got %b want 00", c, s_axis_tready); end
            step();
        end
        lock = 1'b0;
        @(negedge clk);
        vectors++; if (m_axis_tlast !== 2'b00) begin miscompares++; $display("FAIL lock_beat3_tlast got %b want 00", m_axis_tlast); end
        step();
        @(negedge clk);
        vectors++; if (m_axis_tlast !== 2'b11) begin miscompares++; $display("FAIL lock_beat4_tlast got %b want 11", m_axis_tlast); end
        step();
        vectors++; if (operation_complete !== 1'b1) begin miscompares++; $display("FAIL lock_complete got %b want 1", operation_complete); end
        step();
    endtask

    task automatic test_zero_size_ext_err();
        s_axis_tvalid = 2'b11;
        m_axis_tready = 2'b11;
        do_start(32'd0, 16'd3);
        vectors++; if (operation_error !== 1'b1) begin miscompares++; $display("FAIL zero_error got %b want 1", operation_error); end
        vectors++; if (operation_busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy got %b want 0", operation_busy); end
        vectors++; if (m_axis_tvalid !== 2'b00) begin miscompares++; $display("FAIL zero_tvalid got %b want 00", m_axis_tvalid); end
        do_start(32'd4, 16'd3);
        vectors++; if (operation_error !== 1'b0) begin miscompares++; $display("FAIL ext_restart_error got %b want 0", operation_error); end
        for (int b = 1; b <= 7; b++) begin
            external_error = (b == 7);
            step();
        end
        external_error = 1'b0;
        vectors++; if (operation_error !== 1'b1) begin miscompares++; $display("FAIL ext_error got %b want 1", operation_error); end
        vectors++; if (operation_complete !== 1'b0) begin miscompares++; $display("FAIL ext_complete got %b want 0", operation_complete); end
        vectors++; if (operation_busy !== 1'b0) begin miscompares++; $display("FAIL ext_busy got %b want 0", operation_busy); end
        step();
        vectors++; if (operation_complete !== 1'b0) begin miscompares++; $display("FAIL ext_complete_late got %b want 0", operation_complete); end
    endtask

    task automatic test_reset_mid_run();
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_axis_tvalid = 2'b11;
        m_axis_tready = 2'b11;
        do_start(32'd4, 16'd3);
        for (int b = 0; b < 5; b++) step();
        rst = 1'b1;
        step();
        vectors++; if (operation_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", operation_busy); end
        vectors++; if (m_axis_tvalid !== 2'b00) begin miscompares++; $display("FAIL rstmid_tvalid got %b want 00", m_axis_tvalid); end
        vectors++; if (s_axis_tready !== 2'b00) begin miscompares++; $display("FAIL rstmid_tready got %b want 00", s_axis_tready); end
        vectors++; if (channel_done !== 2'b00) begin miscompares++; $display("FAIL rstmid_done got %b want 00", channel_done); end
        vectors++; if (operation_error !== 1'b0) begin miscompares++; $display("FAIL rstmid_error got %b want 0", operation_error); end
        rst = 1'b0;
        do_start(32'd3, 16'd1);
        for (int b = 1; b <= 3; b++) begin
            @(negedge clk);
            vectors++; if (m_axis_tlast !== ((b == 3) ? 2'b11 : 2'b00)) begin miscompares++; $display("FAIL rstmid_tlast beat %0d got %b", b, m_axis_tlast); end
            step();
        end
        vectors++; if (operation_complete !== 1'b1) begin miscompares++; $display("FAIL rstmid_complete got %b want 1", operation_complete); end
    endtask

    initial begin
        rst             = 1'b1;
        operation_start = 1'b0;
        packet_size     = '0;
        packet_count    = '0;
        lock            = 1'b0;
        external_error  = 1'b0;
        s_axis_tdata    = '0;
        s_axis_tkeep    = 4'b1111;
        s_axis_tvalid   = '0;
        s_axis_tlast    = '0;
        s_axis_tid      = '0;
        s_axis_tdest    = '0;
        s_axis_tuser    = '0;
        m_axis_tready   = '0;
        test_reset();
        test_basic_split();
        test_skewed();
        test_nondiv();
        test_lock();
        test_zero_size_ext_err();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
